// File: rtl/pipereg_wb_skid.sv
// pipereg_wb_skid: per-channel 2-entry writeback skid FIFO with ROB-age flush.
// Define PIPEREG_WB_PERF_EN to add the perf_stall_cnt back-pressure counter.
module pipereg_wb_skid #(
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = 64,
   parameter int PREG_W  = 6,
   parameter int ROBID_W = 7
) (
   input  logic                        clock,
   input  logic                        reset_n,
`ifdef PIPEREG_WB_PERF_EN
   output logic [31:0]                 perf_stall_cnt,
`endif
   input  logic [NUM_CH-1:0]           in_valid,
   output logic [NUM_CH-1:0]           in_ready,
   input  logic [NUM_CH-1:0]           in_need_to_wb,
   input  logic [NUM_CH*PREG_W-1:0]    in_prd,
   input  logic [NUM_CH*DATA_W-1:0]    in_result,
   input  logic [NUM_CH*ROBID_W-1:0]   in_robid,
   input  logic                        flush_valid,
   input  logic [ROBID_W-1:0]          flush_robid,
   output logic [NUM_CH-1:0]           out_valid,
   input  logic [NUM_CH-1:0]           out_ready,
   output logic [NUM_CH-1:0]           out_need_to_wb,
   output logic [NUM_CH*PREG_W-1:0]    out_prd,
   output logic [NUM_CH*DATA_W-1:0]    out_result,
   output logic [NUM_CH*ROBID_W-1:0]   out_robid
);
   typedef struct packed {
      logic               need;
      logic [PREG_W-1:0]  prd;
      logic [DATA_W-1:0]  result;
      logic [ROBID_W-1:0] robid;
   } ent_t;

   // Wrap bit flips the sense of the index compare; equal ids are not younger.
   function automatic logic younger(input logic [ROBID_W-1:0] e, input logic [ROBID_W-1:0] f);
      return (e[ROBID_W-1] ^ f[ROBID_W-1]) ^ (e[ROBID_W-2:0] > f[ROBID_W-2:0]);
   endfunction

   ent_t head_q [NUM_CH];
   ent_t head_d [NUM_CH];
   ent_t tail_q [NUM_CH];
   ent_t tail_d [NUM_CH];
   ent_t in_ent [NUM_CH];
   logic [NUM_CH-1:0] hv_q, hv_d, tv_q, tv_d, rdy_q, rdy_d;
   logic [NUM_CH-1:0] hs, ts, enq, deq;

   always_comb begin
      hv_d = '0;
      tv_d = '0;
      rdy_d = '1;
      hs = '0;
      ts = '0;
      enq = '0;
      deq = '0;
      head_d = head_q;
      tail_d = tail_q;
      in_ent = head_q;
      for (int c = 0; c < NUM_CH; c++) begin
         in_ent[c] = {in_need_to_wb[c], in_prd[c*PREG_W +: PREG_W],
                      in_result[c*DATA_W +: DATA_W], in_robid[c*ROBID_W +: ROBID_W]};
         deq[c] = hv_q[c] & out_ready[c];
         enq[c] = in_valid[c] & rdy_q[c] & ~(flush_valid & younger(in_ent[c].robid, flush_robid));
         hs[c] = hv_q[c] & ~deq[c] & ~(flush_valid & younger(head_q[c].robid, flush_robid));
         ts[c] = tv_q[c] & ~(flush_valid & younger(tail_q[c].robid, flush_robid));
         // Survivors pack in age order: head, tail, new; at most two can exist.
         hv_d[c] = hs[c] | ts[c] | enq[c];
         tv_d[c] = (hs[c] & ts[c]) | ((hs[c] | ts[c]) & enq[c]);
         rdy_d[c] = ~tv_d[c];
         head_d[c] = hs[c] ? head_q[c] : ts[c] ? tail_q[c] : enq[c] ? in_ent[c] : head_q[c];
         tail_d[c] = (hs[c] & ts[c]) ? tail_q[c] : ((hs[c] | ts[c]) & enq[c]) ? in_ent[c] : tail_q[c];
      end
   end

   always_comb begin
      out_need_to_wb = '0;
      out_prd = '0;
      out_result = '0;
      out_robid = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         out_need_to_wb[c] = head_q[c].need;
         out_prd[c*PREG_W +: PREG_W] = head_q[c].prd;
         out_result[c*DATA_W +: DATA_W] = head_q[c].result;
         out_robid[c*ROBID_W +: ROBID_W] = head_q[c].robid;
      end
   end

   assign out_valid = hv_q;
   assign in_ready = rdy_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hv_q <= '0;
         tv_q <= '0;
         rdy_q <= '1;
         for (int c = 0; c < NUM_CH; c++) begin
            head_q[c] <= '0;
            tail_q[c] <= '0;
         end
      end else begin
         hv_q <= hv_d;
         tv_q <= tv_d;
         rdy_q <= rdy_d;
         for (int c = 0; c < NUM_CH; c++) begin
            head_q[c] <= head_d[c];
            tail_q[c] <= tail_d[c];
         end
      end
   end

`ifdef PIPEREG_WB_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = ((|(hv_q & ~out_ready)) && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) stall_cnt_q <= '0;
      else stall_cnt_q <= stall_cnt_d;
   end

   assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipereg_wb_skid.sv
// tb_pipereg_wb_skid: scoreboard bench for the writeback skid FIFO, directed plus random traffic.
module tb_pipereg_wb_skid;
   localparam int NC = 2, DW = 64, PW = 6, RW = 7, EW = 1 + PW + DW + RW;
   typedef logic [EW-1:0] ent_t;

   logic clock = 1'b0;
   logic reset_n = 1'b1;
   logic [NC-1:0] in_valid = '0, in_ready, in_need_to_wb = '0;
   logic [NC*PW-1:0] in_prd = '0;
   logic [NC*DW-1:0] in_result = '0;
   logic [NC*RW-1:0] in_robid = '0;
   logic flush_valid = 1'b0;
   logic [RW-1:0] flush_robid = '0;
   logic [NC-1:0] out_valid, out_ready = '0, out_need_to_wb;
   logic [NC*PW-1:0] out_prd;
   logic [NC*DW-1:0] out_result;
   logic [NC*RW-1:0] out_robid;
`ifdef PIPEREG_WB_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] stall_m = '0;
`endif

   ent_t sbq [NC][$];
   int checks = 0, passed = 0;

   pipereg_wb_skid dut (
      .clock(clock), .reset_n(reset_n),
`ifdef PIPEREG_WB_PERF_EN
      .perf_stall_cnt(perf_stall_cnt),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_need_to_wb(in_need_to_wb),
      .in_prd(in_prd), .in_result(in_result), .in_robid(in_robid),
      .flush_valid(flush_valid), .flush_robid(flush_robid),
      .out_valid(out_valid), .out_ready(out_ready), .out_need_to_wb(out_need_to_wb),
      .out_prd(out_prd), .out_result(out_result), .out_robid(out_robid)
   );

   always #5 clock = ~clock;

   // Younger means a forward distance of 1..64 in the 128-id circular space.
   function automatic logic young(input logic [RW-1:0] e, input logic [RW-1:0] f);
      logic [RW-1:0] d;
      d = e - f;
      return (d >= 7'd1) && (d <= 7'd64);
   endfunction

   task automatic drive(input int c, input logic v, input logic [RW-1:0] id, input logic [DW-1:0] r);
      in_valid[c] = v;
      in_robid[c*RW +: RW] = id;
      in_result[c*DW +: DW] = r;
      in_prd[c*PW +: PW] = id[PW-1:0] ^ 6'h2A;
      in_need_to_wb[c] = id[0];
   endtask

   task automatic clear_model();
      sbq[0].delete();
      sbq[1].delete();
`ifdef PIPEREG_WB_PERF_EN
      stall_m = '0;
`endif
   endtask

   task automatic cycle();
      ent_t e, got;
      logic full;
`ifdef PIPEREG_WB_PERF_EN
      if (((sbq[0].size() != 0 && !out_ready[0]) || (sbq[1].size() != 0 && !out_ready[1])) && stall_m != 32'hFFFF_FFFF)
         stall_m = stall_m + 32'd1;
`endif
      for (int c = 0; c < NC; c++) begin
         full = (sbq[c].size() == 2);
         if (sbq[c].size() != 0 && out_ready[c]) void'(sbq[c].pop_front());
         if (flush_valid)
            for (int i = sbq[c].size() - 1; i >= 0; i--) begin
               e = sbq[c][i];
               if (young(e[RW-1:0], flush_robid)) sbq[c].delete(i);
            end
         e = {in_need_to_wb[c], in_prd[c*PW +: PW], in_result[c*DW +: DW], in_robid[c*RW +: RW]};
         if (in_valid[c] && !full && !(flush_valid && young(e[RW-1:0], flush_robid))) sbq[c].push_back(e);
      end
      @(posedge clock);
      #1;
      for (int c = 0; c < NC; c++) begin
         checks++;
         if (out_valid[c] !== (sbq[c].size() != 0))
            $display("FAIL out_valid ch%0d t=%0t: got %b expected %b", c, $time, out_valid[c], sbq[c].size() != 0);
         else passed++;
         checks++;
         if (in_ready[c] !== (sbq[c].size() < 2))
            $display("FAIL in_ready ch%0d t=%0t: got %b expected %b", c, $time, in_ready[c], sbq[c].size() < 2);
         else passed++;
         if (sbq[c].size() != 0) begin
            got = {out_need_to_wb[c], out_prd[c*PW +: PW], out_result[c*DW +: DW], out_robid[c*RW +: RW]};
            checks++;
            if (got !== sbq[c][0])
               $display("FAIL head_payload ch%0d t=%0t: got %h expected %h", c, $time, got, sbq[c][0]);
            else passed++;
         end
      end
`ifdef PIPEREG_WB_PERF_EN
      checks++;
      if (perf_stall_cnt !== stall_m) $display("FAIL perf_cnt t=%0t: got %0d expected %0d", $time, perf_stall_cnt, stall_m);
      else passed++;
`endif
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 2'b11) $display("FAIL reset_in_ready: got %b expected 11", in_ready); else passed++;
      checks++;
      if ({out_valid, out_need_to_wb} !== 4'b0) $display("FAIL reset_out_valid: got %b expected 0000", {out_valid, out_need_to_wb}); else passed++;
      checks++;
      if ({out_prd, out_result, out_robid} !== '0) $display("FAIL reset_payload: got %h expected 0", {out_prd, out_result, out_robid}); else passed++;
      repeat (2) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      clear_model();
      cycle();
   endtask

   task automatic test_single();
      out_ready = 2'b11;
      drive(0, 1'b1, 7'h05, 64'hDEAD);
      cycle();
      in_valid[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b1 || out_result[DW-1:0] !== 64'hDEAD || out_robid[RW-1:0] !== 7'h05)
         $display("FAIL single_latency: got v=%b r=%h id=%h expected v=1 r=dead id=05", out_valid[0], out_result[DW-1:0], out_robid[RW-1:0]);
      else passed++;
      cycle();
      checks++;
      if (out_valid[0] !== 1'b0) $display("FAIL single_drain: got %b expected 0", out_valid[0]); else passed++;
   endtask

   task automatic test_back_to_back();
      out_ready = 2'b01;
      drive(1, 1'b1, 7'h10, 64'h1010);
      cycle();
      drive(1, 1'b1, 7'h11, 64'h1111);
      cycle();
      checks++;
      if (in_ready[1] !== 1'b0) $display("FAIL full_in_ready: got %b expected 0", in_ready[1]); else passed++;
      drive(1, 1'b1, 7'h12, 64'h1212);
      cycle();
      in_valid[1] = 1'b0;
      checks++;
      if (out_robid[2*RW-1:RW] !== 7'h10) $display("FAIL order_first: got %h expected 10", out_robid[2*RW-1:RW]); else passed++;
      out_ready[1] = 1'b1;
      cycle();
      checks++;
      if (out_robid[2*RW-1:RW] !== 7'h11) $display("FAIL order_second: got %h expected 11", out_robid[2*RW-1:RW]); else passed++;
      cycle();
      checks++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1)
         $display("FAIL drained_ch1: got v=%b rdy=%b expected v=0 rdy=1", out_valid[1], in_ready[1]);
      else passed++;
   endtask

   task automatic test_flush();
      out_ready = 2'b00;
      drive(0, 1'b1, 7'h12, 64'hA12);
      cycle();
      drive(0, 1'b1, 7'h14, 64'hA14);
      cycle();
      in_valid[0] = 1'b0;
      flush_valid = 1'b1;
      flush_robid = 7'h13;
      cycle();
      flush_valid = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b1 || out_robid[RW-1:0] !== 7'h12 || in_ready[0] !== 1'b1)
         $display("FAIL flush_tail: got v=%b id=%h rdy=%b expected v=1 id=12 rdy=1", out_valid[0], out_robid[RW-1:0], in_ready[0]);
      else passed++;
      drive(0, 1'b1, 7'h14, 64'hB14);
      cycle();
      in_valid[0] = 1'b0;
      flush_valid = 1'b1;
      flush_robid = 7'h11;
      cycle();
      flush_valid = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1)
         $display("FAIL flush_both: got v=%b rdy=%b expected v=0 rdy=1", out_valid[0], in_ready[0]);
      else passed++;
   endtask

   task automatic test_wrap();
      out_ready = 2'b00;
      drive(0, 1'b1, 7'h41, 64'h41);
      cycle();
      in_valid[0] = 1'b0;
      flush_valid = 1'b1;
      flush_robid = 7'h3E;
      cycle();
      flush_valid = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b0) $display("FAIL wrap_kill: got %b expected 0", out_valid[0]); else passed++;
      drive(0, 1'b1, 7'h3F, 64'h3F);
      cycle();
      in_valid[0] = 1'b0;
      flush_valid = 1'b1;
      flush_robid = 7'h3F;
      cycle();
      flush_valid = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b1 || out_robid[RW-1:0] !== 7'h3F)
         $display("FAIL equal_keep: got v=%b id=%h expected v=1 id=3f", out_valid[0], out_robid[RW-1:0]);
      else passed++;
      out_ready = 2'b11;
      cycle();
      out_ready = 2'b00;
   endtask

   task automatic test_flush_deq();
      out_ready = 2'b00;
      drive(0, 1'b1, 7'h22, 64'h22);
      cycle();
      checks++;
      if (out_robid[RW-1:0] !== 7'h22) $display("FAIL fd_head: got %h expected 22", out_robid[RW-1:0]); else passed++;
      drive(0, 1'b1, 7'h21, 64'h21);
      out_ready[0] = 1'b1;
      flush_valid = 1'b1;
      flush_robid = 7'h20;
      cycle();
      flush_valid = 1'b0;
      in_valid[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1)
         $display("FAIL fd_empty: got v=%b rdy=%b expected v=0 rdy=1", out_valid[0], in_ready[0]);
      else passed++;
   endtask

   task automatic test_reset_mid();
      out_ready = 2'b00;
      drive(0, 1'b1, 7'h30, 64'h30);
      cycle();
      drive(0, 1'b1, 7'h31, 64'h31);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 2'b00 || in_ready !== 2'b11 || out_robid !== '0)
         $display("FAIL mid_reset: got v=%b rdy=%b id=%h expected v=00 rdy=11 id=0", out_valid, in_ready, out_robid);
      else passed++;
      clear_model();
      @(negedge clock) reset_n = 1'b1;
      cycle();
      in_valid[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b1 || out_robid[RW-1:0] !== 7'h31)
         $display("FAIL first_after_reset: got v=%b id=%h expected v=1 id=31", out_valid[0], out_robid[RW-1:0]);
      else passed++;
      out_ready = 2'b11;
      cycle();
   endtask

`ifdef PIPEREG_WB_PERF_EN
   task automatic test_perf();
      #1 reset_n = 1'b0;
      clear_model();
      @(negedge clock) reset_n = 1'b1;
      out_ready = 2'b00;
      drive(0, 1'b1, 7'h01, 64'h1);
      cycle();
      in_valid[0] = 1'b0;
      repeat (7) cycle();
      checks++;
      if (perf_stall_cnt !== 32'd7) $display("FAIL perf_seven: got %0d expected 7", perf_stall_cnt); else passed++;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (perf_stall_cnt !== 32'd0 || out_valid !== 2'b00)
         $display("FAIL perf_reset: got cnt=%0d v=%b expected cnt=0 v=00", perf_stall_cnt, out_valid);
      else passed++;
      clear_model();
      @(negedge clock) reset_n = 1'b1;
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         out_ready = 2'($urandom);
         for (int c = 0; c < NC; c++)
            drive(c, 1'($urandom), 7'($urandom), {32'($urandom), 32'($urandom)});
         flush_valid = ($urandom_range(0, 7) == 0);
         flush_robid = 7'($urandom);
         cycle();
      end
      flush_valid = 1'b0;
      in_valid = '0;
      out_ready = 2'b11;
      repeat (3) cycle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_flush();
      test_wrap();
      test_flush_deq();
      test_reset_mid();
`ifdef PIPEREG_WB_PERF_EN
      test_perf();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
